// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: block geometry, FILL/FULL encoding and block type shared by the PISO, SIPO and AES wrapper
package aes_uart_pkg;
  localparam int BLOCK_W = 128;
  localparam int BYTE_W = 8;
  localparam int BYTES_PER_BLOCK = 16;
  localparam logic ST_FILL = 1'b0;
  localparam logic ST_FULL = 1'b1;
  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/sipo_128_idle_timer.sv
// idle_timer: saturating idle counter, cleared on load, pulses expire on the idle cycle after reaching TIMEOUT_CYCLES-1
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt;
  assign expire = (TIMEOUT_CYCLES != 0) && enable && cnt == CW'(TIMEOUT_CYCLES - 1);
  // count idle cycles, restart after expiry, never wrap
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (enable && TIMEOUT_CYCLES != 0) cnt <= expire ? '0 : (&cnt ? cnt : cnt + 1'b1);
  end
endmodule

// File: rtl/sipo_128.sv
// sipo_128: assembles 16 serial bytes MSB-first into a 128-bit block with valid/ready, overrun and inter-byte timeout
module sipo_128
  import aes_uart_pkg::*;
#(
  parameter int DATA_W = BYTE_W,
  parameter int NUM_WORDS = BYTES_PER_BLOCK,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [DATA_W-1:0]           byte_in,
  input  logic                        byte_valid,
  output logic [DATA_W*NUM_WORDS-1:0] parallel_out,
  output logic                        block_valid,
  input  logic                        block_ready,
  output logic                        empty,
  output logic [4:0]                  byte_count,
  output logic                        overrun,
  output logic                        timeout
);
  logic                        state;
  logic [DATA_W*NUM_WORDS-1:0] sr;
  logic                        idle;
  logic                        expire;
  assign idle = state == ST_FILL && byte_count != 5'd0 && !byte_valid;
  assign parallel_out = sr;
  assign block_valid = state == ST_FULL;
  assign empty = state == ST_FILL && byte_count == 5'd0;
  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear || !idle),
    .enable(idle),
    .expire(expire)
  );
  // shift register, byte count and FILL/FULL control; a held block only leaves on handshake or clear
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr         <= '0;
      state      <= ST_FILL;
      byte_count <= 5'd0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= expire;
      if (state == ST_FULL) begin
        if (block_ready) begin
          state      <= ST_FILL;
          byte_count <= byte_valid ? 5'd1 : 5'd0;
          if (byte_valid) sr <= {sr[DATA_W*(NUM_WORDS-1)-1:0], byte_in};
        end else if (byte_valid) begin
          overrun <= 1'b1;
        end
      end else if (byte_valid) begin
        sr         <= {sr[DATA_W*(NUM_WORDS-1)-1:0], byte_in};
        byte_count <= byte_count + 5'd1;
        if (byte_count == 5'(NUM_WORDS - 1)) state <= ST_FULL;
      end else if (expire) begin
        byte_count <= 5'd0;
      end
    end
  end
endmodule
